// File: rtl/truth_table_sweeper.sv
// Built-in self-test sweeper: walks every input vector through a combinational block, captures its truth table, compares to expected.
// Optional TTS_EARLY_ABORT_EN ends the sweep at the first mismatching vector.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [(1<<N_IN)-1:0] expected,
  output logic [N_IN-1:0]      stim,
  input  logic                 resp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  // `table` is a reserved word, so the captured table leaves on tbl.
  output logic [(1<<N_IN)-1:0] tbl,
  output logic [N_IN-1:0]      fail_idx
);

  localparam int NV = 1 << N_IN;
  localparam logic [N_IN:0] IDX_END = {1'b1, {N_IN{1'b0}}};
  localparam logic [3:0] CNT_LAST = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, HOLD, FINISH} state_t;

  state_t          state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            miss_q, miss_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [N_IN-1:0] fail_q, fail_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [NV-1:0]   tbl_q, tbl_d;
  logic [N_IN-1:0] cur;
  logic            bad;
  logic            last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    stim_d  = stim_q;
    fail_d  = fail_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    tbl_d   = tbl_q;
    cur     = idx_q[N_IN-1:0];
    bad     = 1'b0;
    last    = 1'b0;
    case (state_q)
      // FINISH accepts start too, so sweeps can run back to back.
      IDLE, FINISH: begin
        if (start) begin
          state_d = HOLD;
          busy_d  = 1'b1;
          stim_d  = '0;
          tbl_d   = '0;
          pass_d  = 1'b0;
          fail_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          miss_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          bad        = (resp != expected[cur]);
          tbl_d[cur] = resp;
          if (bad && !miss_q) fail_d = cur;
          miss_d = miss_q | bad;
          idx_d  = idx_q + 1'b1;
          stim_d = idx_d[N_IN-1:0];
`ifdef TTS_EARLY_ABORT_EN
          last = (idx_d == IDX_END) || bad;
`else
          last = (idx_d == IDX_END);
`endif
          if (last) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stim_d  = '0;
            pass_d  = !miss_d;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      miss_q  <= 1'b0;
      stim_q  <= '0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tbl_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      stim_q  <= stim_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tbl_q   <= tbl_d;
    end
  end

  assign stim     = stim_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign tbl      = tbl_q;
  assign fail_idx = fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper (N_IN=4, SETTLE=1) against a closed-form sweep model.
module tb_truth_table_sweeper;
  localparam int P = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] expected;
  logic [15:0] func_tt;
  logic [3:0]  stim;
  logic        resp;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] tbl;
  logic [3:0]  fail_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Combinational block under test: an arbitrary truth table indexed by stim.
  assign resp = func_tt[stim];

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .expected (expected),
    .stim     (stim),
    .resp     (resp),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .tbl      (tbl),
    .fail_idx (fail_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_miss(input logic [15:0] ft, input logic [15:0] ex);
    for (int i = 0; i < 16; i++)
      if (ft[i] != ex[i]) return i;
    return 16;
  endfunction

  function automatic logic [15:0] low_mask(input int n);
    logic [31:0] m;
    m = (32'd1 << n) - 32'd1;
    return (n >= 16) ? 16'hFFFF : m[15:0];
  endfunction

  function automatic int sweep_edges(input int fm);
`ifdef TTS_EARLY_ABORT_EN
    return ((fm == 16) ? 16 : fm + 1) * P;
`else
    return 16 * P;
`endif
  endfunction

  // Model: at acceptance the whole sweep outcome is known; outputs are
  // then a function of the edge count k since E0.
  bit          m_run = 1'b0;
  int          m_k = 0, m_end = 0, m_fm = 16, m_n = 0;
  logic [15:0] m_final = '0;
  logic [3:0]  m_stim = '0, m_fidx = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0;
  logic [15:0] m_tbl = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 1'b0; m_stim = '0; m_busy = 1'b0; m_done = 1'b0;
      m_pass = 1'b0; m_tbl = '0; m_fidx = '0;
    end else begin
      m_done = 1'b0;
      if (m_run) begin
        m_k++;
        m_n = m_k / P;
        m_tbl = m_final & low_mask(m_n);
        m_fidx = (m_fm < m_n) ? 4'(m_fm) : 4'd0;
        if (m_k == m_end) begin
          m_run = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_stim = '0;
          m_pass = (m_fm == 16);
        end else begin
          m_stim = 4'(m_n);
        end
      end else if (start) begin
        m_final = func_tt;
        m_fm = first_miss(func_tt, expected);
        m_end = sweep_edges(m_fm);
        m_run = 1'b1; m_k = 0; m_busy = 1'b1; m_stim = '0;
        m_tbl = '0; m_pass = 1'b0; m_fidx = '0;
      end
    end
  end

  always @(negedge clk) begin
    chk("stim", 32'(stim), 32'(m_stim));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("pass", 32'(pass), 32'(m_pass));
    chk("tbl", 32'(tbl), 32'(m_tbl));
    chk("fail_idx", 32'(fail_idx), 32'(m_fidx));
  end

  // Launch a sweep; returns #1 after the edge that raises done (lat = edges since E0).
  task automatic sweep(input logic [15:0] ft, input logic [15:0] ex, input int pulse_at, output int lat);
    @(negedge clk);
    func_tt = ft; expected = ex; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
      if (lat == pulse_at) start = 1'b1;
      else if (lat == pulse_at + 1) start = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, gap, idle, fm;
    bit seen;
    logic [15:0] ft, ex;

    rst_n = 1'b0; start = 1'b0; expected = '0; func_tt = 16'hF888;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_stim", 32'(stim), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_tbl", 32'(tbl), 32'h0000);
    chk("rst_fail_idx", 32'(fail_idx), 32'd0);

    // y = (a&b)|(c&d) has truth table F888.
    sweep(16'hF888, 16'hF888, -1, lat);
    chk("pass_lat", 32'(lat), 32'd32);
    @(negedge clk);
    chk("pass_tbl", 32'(tbl), 32'hF888);
    chk("pass_pass", 32'(pass), 32'd1);
    chk("pass_fidx", 32'(fail_idx), 32'd0);

    sweep(16'hF888, 16'hF88C, -1, lat);
    @(negedge clk);
`ifdef TTS_EARLY_ABORT_EN
    chk("fail_lat", 32'(lat), 32'd6);
    chk("fail_tbl", 32'(tbl), 32'h0000);
`else
    chk("fail_lat", 32'(lat), 32'd32);
    chk("fail_tbl", 32'(tbl), 32'hF888);
`endif
    chk("fail_pass", 32'(pass), 32'd0);
    chk("fail_fidx", 32'(fail_idx), 32'd2);

    // start re-pulsed while stim = 5 must not disturb the sweep.
    sweep(16'hF888, 16'hF888, 10, lat);
    chk("repulse_lat", 32'(lat), 32'd32);
    repeat (3) @(negedge clk);

    // Reset while stim = 9.
    @(negedge clk);
    func_tt = 16'hF888; expected = 16'hF888; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (18) @(posedge clk);
    #1 chk("stim_at_18", 32'(stim), 32'd9);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_stim", 32'(stim), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    // Back-to-back: start held high across two sweeps.
    @(negedge clk);
    func_tt = 16'hF888; expected = 16'hF888; start = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1 if (done) break;
    end
    chk("b2b_lat1", 32'(lat), 32'd32);
    idle = busy ? 0 : 1;
    gap = 0;
    while (gap < 200) begin
      @(posedge clk);
      gap++;
      #1 if (done) break;
      if (!busy) idle++;
    end
    start = 1'b0;
    chk("b2b_gap", 32'(gap), 32'd33);
    chk("b2b_idle", 32'(idle), 32'd1);
    repeat (3) @(negedge clk);

    for (int r = 0; r < 30; r++) begin
      ft = 16'($urandom);
      case ($urandom_range(0, 2))
        0: ex = ft;
        1: ex = ft ^ (16'h1 << $urandom_range(0, 15));
        default: ex = 16'($urandom);
      endcase
      fm = first_miss(ft, ex);
      sweep(ft, ex, -1, lat);
      chk("rand_lat", 32'(lat), 32'(sweep_edges(fm)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
